ds_laser_packer: RTL

Downstream stage of the uniform down-sampler. It takes the per-sample stream (valid, data, lost marker, acc/zero flags) and discards every sample marked lost. It packs the surviving 16-bit samples four to a word, flushes a partial word at the end of each acquisition window, and buffers words in a small FWFT FIFO. The FIFO is drained over a valid/ready stream toward the upload/DDR path.

---
 rtl/pmt_pack_pkg.sv | 20 ++
 rtl/pack_sync_fifo.sv | 55 +++++
 rtl/ds_laser_packer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pmt_pack_pkg.sv
// Shared geometry for the laser sample packer: default widths and derived sizes.
package pmt_pack_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned PACK_NUM_DEF   = 4;

    function automatic int unsigned pack_width(input int unsigned dw, input int unsigned pn);
        return dw * pn;
    endfunction

    function automatic int unsigned lane_cnt_w(input int unsigned pn);
        return $clog2(pn);
    endfunction

    // FIFO entry layout is {zero, last, keep, data}
    function automatic int unsigned entry_width(input int unsigned dw, input int unsigned pn);
        return dw * pn + pn + 2;
    endfunction

endpackage

// File: rtl/pack_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module pack_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       full,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign do_rd   = rd_en & ~empty;
    // A write into a full FIFO is legal when the head leaves in the same cycle
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/ds_laser_packer.sv
// Drops lost samples, packs survivors PACK_NUM per word, flushes at window end,
// and buffers words in an FWFT FIFO with overflow accounting.
module ds_laser_packer
    import pmt_pack_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned PACK_NUM   = PACK_NUM_DEF,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           ds_acc_flag_i,
    input  logic                           ds_zero_flag_i,
    input  logic                           ds_laser_vld_i,
    input  logic [DATA_WIDTH-1:0]          ds_laser_data_i,
    input  logic                           ds_laser_lost_i,
    output logic                           pack_vld_o,
    input  logic                           pack_rdy_i,
    output logic [DATA_WIDTH*PACK_NUM-1:0] pack_data_o,
    output logic [PACK_NUM-1:0]            pack_keep_o,
    output logic                           pack_last_o,
    output logic                           pack_zero_o,
    output logic                           pack_ovf_o,
    output logic [15:0]                    pack_drop_cnt_o
);

    localparam int unsigned PACK_WIDTH = pack_width(DATA_WIDTH, PACK_NUM);
    localparam int unsigned LANE_CNT_W = lane_cnt_w(PACK_NUM);
    localparam int unsigned ENTRY_W    = entry_width(DATA_WIDTH, PACK_NUM);
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Input stage
    logic                  in_vld_q;
    logic                  in_lost_q;
    logic                  in_acc_q;
    logic                  in_zero_q;
    logic [DATA_WIDTH-1:0] in_data_q;
    logic                  acc_prev_q;

    // Pack stage
    logic [LANE_CNT_W-1:0] cnt_q,   cnt_n;
    logic [PACK_WIDTH-1:0] lanes_q, lanes_n;
    logic [PACK_NUM-1:0]   keep_q,  keep_n;
    logic                  zero_q,  zero_n;
    logic                  wr_en_q, wr_en_n;
    logic [ENTRY_W-1:0]    wr_data_q, wr_data_n;

    logic                  accept;
    logic                  acc_fall;
    logic                  acc_rise;

    // FIFO and overflow accounting
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_rd;
    logic                  drop;
    logic [ENTRY_W-1:0]    fifo_rd_data;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  ovf_q;
    logic [15:0]           drop_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_vld_q   <= 1'b0;
            in_lost_q  <= 1'b0;
            in_acc_q   <= 1'b0;
            in_zero_q  <= 1'b0;
            in_data_q  <= '0;
            acc_prev_q <= 1'b0;
        end else begin
            in_vld_q   <= ds_laser_vld_i;
            in_lost_q  <= ds_laser_lost_i;
            in_acc_q   <= ds_acc_flag_i;
            in_zero_q  <= ds_zero_flag_i;
            in_data_q  <= ds_laser_data_i;
            acc_prev_q <= in_acc_q;
        end
    end

    assign accept   = in_vld_q & ~in_lost_q & in_acc_q;
    assign acc_fall = acc_prev_q & ~in_acc_q;
    assign acc_rise = ~acc_prev_q & in_acc_q;

    // Lane accumulation, word completion and window-end flush
    always_comb begin
        cnt_n     = cnt_q;
        lanes_n   = lanes_q;
        keep_n    = keep_q;
        zero_n    = zero_q;
        wr_en_n   = 1'b0;
        wr_data_n = '0;

        if (acc_fall) begin
            // With nothing accumulated the accumulators are already zero: a marker word
            wr_en_n   = 1'b1;
            wr_data_n = {zero_q, 1'b1, keep_q, lanes_q};
            cnt_n     = '0;
            lanes_n   = '0;
            keep_n    = '0;
            zero_n    = 1'b0;
        end else begin
            if (acc_rise) begin
                cnt_n   = '0;
                lanes_n = '0;
                keep_n  = '0;
                zero_n  = 1'b0;
            end
            if (accept) begin
                for (int unsigned l = 0; l < PACK_NUM; l++) begin
                    if (cnt_n == LANE_CNT_W'(l)) begin
                        lanes_n[l*DATA_WIDTH +: DATA_WIDTH] = in_data_q;
                        keep_n[l]                           = 1'b1;
                    end
                end
                zero_n = zero_n | in_zero_q;
                if (cnt_n == LANE_CNT_W'(PACK_NUM - 1)) begin
                    wr_en_n   = 1'b1;
                    wr_data_n = {zero_n, 1'b0, keep_n, lanes_n};
                    cnt_n     = '0;
                    lanes_n   = '0;
                    keep_n    = '0;
                    zero_n    = 1'b0;
                end else begin
                    cnt_n = cnt_n + LANE_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            lanes_q   <= '0;
            keep_q    <= '0;
            zero_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            cnt_q     <= cnt_n;
            lanes_q   <= lanes_n;
            keep_q    <= keep_n;
            zero_q    <= zero_n;
            wr_en_q   <= wr_en_n;
            wr_data_q <= wr_data_n;
        end
    end

    assign fifo_rd = pack_rdy_i & ~fifo_empty;
    assign drop    = wr_en_q & fifo_full & ~fifo_rd;

    pack_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en   (wr_en_q),
        .wr_data (wr_data_q),
        .full    (fifo_full),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Sticky overflow and saturating drop counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign pack_vld_o      = (fifo_count != '0);
    assign {pack_zero_o, pack_last_o, pack_keep_o, pack_data_o} = fifo_rd_data;
    assign pack_ovf_o      = ovf_q;
    assign pack_drop_cnt_o = drop_cnt_q;

endmodule
